mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (cRamDepth x 32 bit words, 1-cycle read latency) between the instruction-fetch port and the ALU data-memory port (tMemOp).
- Arbitrates between the two ports, formats byte/half/word stores into byte-enables, and sign- or zero-extends loads.
- Returns fetch words to the fetch stage and load results as a tRegOp to write-back.
- Sits between the fetch/ALU stages and the RAM macro.

Parameters:
- pDepth, cRamDepth, RAM depth in 32-bit words (power of two).
- pMaxDataStreak, 4, maximum consecutive data grants while fetch is waiting (range 1..15).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- ifReq  in  1  fetch request; held with ifAddr until ifRdy=1
- ifAddr  in  cXLEN  fetch byte address; bits [1:0] ignored
- ifRdy  out  1  fetch command accepted this cycle
- ifRspDv  out  1  fetch word valid
- ifRspData  out  cXLEN  fetched instruction word
- flush  in  1  pipe flush (tBranchOp.flushPipe); cancels in-flight fetch response
- dmReq  in  $bits(tMemOp)  data op; active when .read or .write is set; held until dmRdy=1
- dmRdy  out  1  data command accepted this cycle
- dmRsp  out  $bits(tRegOp)  load result: .dv, .addr=rdAddr, .data=extended value
- dmErr  out  1  one-cycle pulse on misaligned or illegal data op
- ramEn  out  1  RAM cycle enable
- ramWe  out  4  RAM byte write enables
- ramAddr  out  $clog2(pDepth)  RAM word address
- ramWData  out  cXLEN  RAM write data, lane-replicated
- ramRData  in  cXLEN  RAM read data, valid the cycle after ramEn with ramWe=0

Behaviour:

Reset:
- Async on rstn low.
- ifRspDv=0, dmRsp=cRegOp, dmErr=0, ramEn=0, ramWe=0, streak counter=0, FSM=eArbIdle.
- Any in-flight read is discarded; no response after reset release.

Handshake:
- ifRdy and dmRdy are combinational from the current requests and the streak counter.
- At most one is high per cycle. The accepted command drives the ramEn/ramWe/ramAddr/ramWData outputs in the same cycle.
- A new command may issue every cycle, including the cycle its predecessor's response returns.

Arbitration:
- Only one requesting: that port is granted.
- Both requesting: data wins unless streak==pMaxDataStreak, in which case fetch wins.
- streak counter:
  - Increments on a data grant while ifReq=1.
  - Clears on a fetch grant or whenever ifReq=0.
  - Saturates at pMaxDataStreak.
- flush=1 does not block grants in that cycle.

FSM (owner of the in-flight read):
- States: eArbIdle, eArbIfRsp, eArbDmRsp.
- Next state is set by the grant of this cycle:
  - fetch grant -> eArbIfRsp
  - data read grant (aligned) -> eArbDmRsp
  - otherwise -> eArbIdle
- Responses in the cycle after the grant (latency 1):
  - eArbIfRsp: ifRspDv=1, ifRspData=ramRData.
  - eArbDmRsp: dmRsp.dv=1, registered rdAddr, extended data.

Flush:
- flush=1 while in eArbIfRsp, or in the grant cycle of a fetch, suppresses that ifRspDv.
- Data responses are never suppressed by flush.

Address:
- ramAddr = addr[$clog2(pDepth)+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.

Stores (opType = funct3):
- SB (000): ramWe = 1 << addr[1:0]; data[7:0] replicated x4.
- SH (001): ramWe = 0011 or 1100 by addr[1]; data[15:0] replicated x2.
- SW (010): ramWe = 1111.
- Stores produce no response.

Loads (opType):
- LB (000) / LBU (100): byte lane addr[1:0], sign- or zero-extended.
- LH (001) / LHU (101): half lane addr[1], sign- or zero-extended.
- LW (010): full word.

Errors:
- Misaligned op: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Still granted (dmRdy=1), but ramEn=0.
  - dmErr pulses the following cycle.
  - A misaligned load also returns dmRsp.dv=1 with data=0 in that cycle.
- read=1 and write=1 together: treated as illegal; granted, no RAM access, dmErr pulse, no dmRsp.
- Undefined opType (011, 110, 111): same handling as illegal.

Decomposition:
- Add to corePckg:
  - tArbStateEnum (eArbIdle, eArbIfRsp, eArbDmRsp).
  - tLsSizeEnum, encoding funct3 load/store sizes (eLsB=000, eLsH=001, eLsW=010, eLsBU=100, eLsHU=101).
- One sub-module, mem_lane_align: purely combinational store byte-enable/data replication and load lane select/extension. Instantiated once.
- The arbiter and FSM stay in mem_port_arbiter.

Test Plan:
- Fetch only: ifReq=1, ifAddr=0x10 for 3 cycles, RAM word 4=0x00A00093 -> ifRdy=1 each cycle; ifRspDv=1 one cycle after each grant with 0x00A00093.
- Contention: ifReq and SW dmReq held continuously, pMaxDataStreak=4 -> grant pattern D,D,D,D,F repeating; no fetch wait exceeds 4 cycles.
- Load extension:
  - Word 0x8000_F0FF at addr 0x20, LB @0x20 -> 0xFFFF_FFFF.
  - LBU @0x21 -> 0x0000_00F0.
  - LH @0x22 -> 0xFFFF_8000.
  - LHU @0x22 -> 0x0000_8000.
  - rdAddr echoed in dmRsp.addr.
- Stores:
  - SB data 0xAB @0x33 -> ramWe=1000, ramWData=0xABABABAB.
  - SH @0x32 -> ramWe=1100.
  - SW @0x31 -> ramEn=0, dmErr pulse next cycle, no dmRsp.
- Flush: fetch granted at cycle N, flush=1 at N+1 -> ifRspDv=0 at N+1; a data load granted in the same window still returns dmRsp.dv=1.
- Reset mid-op: assert rstn=0 in the cycle after a load grant -> dmRsp.dv=0 immediately; after release with no requests, all outputs stay at reset values.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared core types for the memory port arbiter: memory/register ops,
// arbiter FSM states, load/store size encodings and op legality helpers.
package mem_port_arbiter_pkg;

    localparam int cXLEN     = 32;
    localparam int cRamDepth = 256;
    localparam int cRegAddrW = 5;

    typedef enum logic [1:0] {
        eArbIdle  = 2'd0,
        eArbIfRsp = 2'd1,
        eArbDmRsp = 2'd2
    } tArbStateEnum;

    typedef enum logic [2:0] {
        eLsB  = 3'b000,
        eLsH  = 3'b001,
        eLsW  = 3'b010,
        eLsBU = 3'b100,
        eLsHU = 3'b101
    } tLsSizeEnum;

    typedef struct packed {
        logic                 read;
        logic                 write;
        logic [2:0]           opType;
        logic [cXLEN-1:0]     addr;
        logic [cXLEN-1:0]     data;
        logic [cRegAddrW-1:0] rdAddr;
    } tMemOp;

    typedef struct packed {
        logic                 dv;
        logic [cRegAddrW-1:0] addr;
        logic [cXLEN-1:0]     data;
    } tRegOp;

    localparam tRegOp cRegOp = '{dv: 1'b0, addr: 5'd0, data: 32'd0};

    // Unsigned sizes exist only for loads.
    function automatic logic ls_legal(input logic [2:0] op, input logic is_store);
        case (op)
            3'b000, 3'b001, 3'b010: ls_legal = 1'b1;
            3'b100, 3'b101:         ls_legal = !is_store;
            default:                ls_legal = 1'b0;
        endcase
    endfunction

    function automatic logic ls_aligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            3'b001, 3'b101: ls_aligned = (lo[0] == 1'b0);
            3'b010:         ls_aligned = (lo == 2'b00);
            default:        ls_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane formatting: store byte enables / data replication and
// load lane selection with sign or zero extension. Purely combinational.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]       st_type,
    input  logic [1:0]       st_lo,
    input  logic [cXLEN-1:0] st_data,
    output logic [3:0]       st_we,
    output logic [cXLEN-1:0] st_wdata,
    input  logic [2:0]       ld_type,
    input  logic [1:0]       ld_lo,
    input  logic [cXLEN-1:0] ld_rdata,
    output logic [cXLEN-1:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store side: lane enables from the low address bits, data replicated so any lane lines up.
    always_comb begin
        st_we    = 4'b0000;
        st_wdata = 32'd0;
        case (st_type)
            eLsB: begin
                st_we    = 4'b0001 << st_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            eLsH: begin
                st_we    = st_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            eLsW: begin
                st_we    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_we    = 4'b0000;
                st_wdata = 32'd0;
            end
        endcase
    end

    // Load side: pick the addressed lane and extend it to a full register.
    always_comb begin
        ld_byte_s = ld_rdata[8*ld_lo +: 8];
        ld_half_s = ld_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_type)
            eLsB:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            eLsBU:   ld_data = {24'd0, ld_byte_s};
            eLsH:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            eLsHU:   ld_data = {16'd0, ld_half_s};
            eLsW:    ld_data = ld_rdata;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// data-memory port; owns the single in-flight read and formats load results.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int pDepth         = cRamDepth,
    parameter int pMaxDataStreak = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ifReq,
    input  logic [cXLEN-1:0]          ifAddr,
    output logic                      ifRdy,
    output logic                      ifRspDv,
    output logic [cXLEN-1:0]          ifRspData,
    input  logic                      flush,
    input  tMemOp                     dmReq,
    output logic                      dmRdy,
    output tRegOp                     dmRsp,
    output logic                      dmErr,
    output logic                      ramEn,
    output logic [3:0]                ramWe,
    output logic [$clog2(pDepth)-1:0] ramAddr,
    output logic [cXLEN-1:0]          ramWData,
    input  logic [cXLEN-1:0]          ramRData
);

    localparam int         cAw      = $clog2(pDepth);
    localparam logic [1:0] ST_IDLE  = 2'(eArbIdle);
    localparam logic [1:0] ST_IFRSP = 2'(eArbIfRsp);
    localparam logic [1:0] ST_DMRSP = 2'(eArbDmRsp);

    logic [1:0]           state_q, state_d;
    logic [3:0]           streak_q, streak_d;
    logic                 err_q, err_d;
    logic                 mis_ld_q, mis_ld_d;
    logic                 if_flush_q, if_flush_d;
    logic [2:0]           ld_type_q, ld_type_d;
    logic [1:0]           ld_lo_q, ld_lo_d;
    logic [cRegAddrW-1:0] rd_addr_q, rd_addr_d;

    logic                 dm_active_s, streak_full_s, dm_gnt_s, if_gnt_s;
    logic                 dm_illegal_s, dm_misal_s, dm_ok_s, if_dv_s;
    logic [3:0]           st_we_s;
    logic [cXLEN-1:0]     st_wdata_s, ld_data_s;
    logic                 unused_s;

    assign unused_s = ^{ifAddr[cXLEN-1:cAw+2], ifAddr[1:0], dmReq.addr[cXLEN-1:cAw+2]};

    mem_lane_align u_lane (
        .st_type  (dmReq.opType),
        .st_lo    (dmReq.addr[1:0]),
        .st_data  (dmReq.data),
        .st_we    (st_we_s),
        .st_wdata (st_wdata_s),
        .ld_type  (ld_type_q),
        .ld_lo    (ld_lo_q),
        .ld_rdata (ramRData),
        .ld_data  (ld_data_s)
    );

    // Grant selection and RAM command drive for the accepted port.
    always_comb begin
        dm_active_s   = dmReq.read | dmReq.write;
        streak_full_s = (streak_q == 4'(pMaxDataStreak));
        dm_gnt_s      = dm_active_s && !(ifReq && streak_full_s);
        if_gnt_s      = ifReq && !dm_gnt_s;
        dm_illegal_s  = (dmReq.read && dmReq.write) || !ls_legal(dmReq.opType, dmReq.write);
        dm_misal_s    = !dm_illegal_s && !ls_aligned(dmReq.opType, dmReq.addr[1:0]);
        dm_ok_s       = dm_gnt_s && !dm_illegal_s && !dm_misal_s;

        ifRdy    = if_gnt_s;
        dmRdy    = dm_gnt_s;
        ramEn    = if_gnt_s || dm_ok_s;
        ramWe    = (dm_ok_s && dmReq.write) ? st_we_s : 4'b0000;
        ramWData = (dm_ok_s && dmReq.write) ? st_wdata_s : 32'd0;
        if (if_gnt_s) begin
            ramAddr = ifAddr[cAw+1:2];
        end else if (dm_gnt_s) begin
            ramAddr = dmReq.addr[cAw+1:2];
        end else begin
            ramAddr = '0;
        end
    end

    // Next-state: read ownership, streak tracking and captured load formatting.
    always_comb begin
        if (if_gnt_s) begin
            state_d = ST_IFRSP;
        end else if (dm_ok_s && dmReq.read) begin
            state_d = ST_DMRSP;
        end else begin
            state_d = ST_IDLE;
        end

        if (!ifReq || if_gnt_s) begin
            streak_d = 4'd0;
        end else if (dm_gnt_s && !streak_full_s) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end

        err_d      = dm_gnt_s && (dm_illegal_s || dm_misal_s);
        mis_ld_d   = dm_gnt_s && dm_misal_s && dmReq.read;
        if_flush_d = if_gnt_s && flush;

        if (dm_gnt_s && dmReq.read) begin
            ld_type_d = dmReq.opType;
            ld_lo_d   = dmReq.addr[1:0];
            rd_addr_d = dmReq.rdAddr;
        end else begin
            ld_type_d = ld_type_q;
            ld_lo_d   = ld_lo_q;
            rd_addr_d = rd_addr_q;
        end
    end

    // Responses return one cycle after the grant, straight from the RAM read port.
    always_comb begin
        if_dv_s   = (state_q == ST_IFRSP) && !flush && !if_flush_q;
        ifRspDv   = if_dv_s;
        ifRspData = if_dv_s ? ramRData : 32'd0;
        dmErr     = err_q;
        if (state_q == ST_DMRSP) begin
            dmRsp = '{dv: 1'b1, addr: rd_addr_q, data: ld_data_s};
        end else if (mis_ld_q) begin
            dmRsp = '{dv: 1'b1, addr: rd_addr_q, data: 32'd0};
        end else begin
            dmRsp = cRegOp;
        end
    end

    // State registers; reset drops any in-flight read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            streak_q   <= 4'd0;
            err_q      <= 1'b0;
            mis_ld_q   <= 1'b0;
            if_flush_q <= 1'b0;
            ld_type_q  <= 3'd0;
            ld_lo_q    <= 2'd0;
            rd_addr_q  <= 5'd0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            err_q      <= err_d;
            mis_ld_q   <= mis_ld_d;
            if_flush_q <= if_flush_d;
            ld_type_q  <= ld_type_d;
            ld_lo_q    <= ld_lo_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

endmodule
